// File: rtl/n_bit_register_pipe.sv
// Elastic STAGES-deep WIDTH-bit register pipe with valid/ready on both sides, bubble collapsing and flush.
// Latency STAGES cycles into an empty pipe; ready_o falls only when all stages are full and ready_i is low.
// Optional occupancy output count_o is built when STAGE_COUNT_EN is defined.
module n_bit_register_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            flush_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [WIDTH-1:0]                data_i,
  output logic                            valid_o,
  input  logic                            ready_i,
`ifdef STAGE_COUNT_EN
  output logic [$clog2(STAGES+1)-1:0]     count_o,
`endif
  output logic [WIDTH-1:0]                data_o
);

  logic [STAGES-1:0] v_q, v_d;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic              all_full_ahead;
  logic              in_xfer;
  logic              out_xfer;

  // A stage advances when downstream accepts or any later stage is empty;
  // expressed without self-reference to keep the chain a plain OR tree.
  always_comb begin
    adv            = '0;
    load           = '0;
    all_full_ahead = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]         = ready_i || !all_full_ahead;
      load[k]        = !v_q[k] || adv[k];
      all_full_ahead = all_full_ahead && v_q[k];
    end
  end

  assign ready_o  = load[0] && !flush_i;
  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = v_q[STAGES-1] && ready_i;
  assign valid_o  = v_q[STAGES-1];
  assign data_o   = d_q[STAGES-1];

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush_i) begin
      v_d = '0;
      for (int k = 0; k < STAGES; k++) d_d[k] = '0;
    end else begin
      if (load[0]) begin
        v_d[0] = in_xfer;
        d_d[0] = data_i;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          v_d[k] = v_q[k-1];
          d_d[k] = d_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) d_q[k] <= '0;
    end else begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) d_q[k] <= d_d[k];
    end
  end

`ifdef STAGE_COUNT_EN
  localparam int CW = $clog2(STAGES + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (in_xfer && !out_xfer) begin
      count_d = count_q + CW'(1);
    end else if (out_xfer && !in_xfer) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;
`endif

endmodule
